div32_seq: RTL

Iterative 32-bit unsigned divider for the execution units: the sequential inverse of the multiply path. It accepts a dividend/divisor pair over a valid/ready handshake and produces one quotient bit per cycle by restoring shift-subtract. Each subtraction runs on a combinational 33-bit subtract. Quotient and remainder are returned over a second valid/ready handshake, so the scoreboard can hold the unit busy for a fixed, known latency.

---
 rtl/div32_seq.sv | 110 +++++++++++
 1 files changed

// File: rtl/div32_seq.sv
// Iterative 32-bit unsigned restoring divider that produces one quotient bit per cycle.
// Operands and results use valid/ready handshakes. A zero divisor returns immediately with a flag.
module div32_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [WIDTH:0]   r;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   t;
    logic [WIDTH:0]   s;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH:0]   r_next;

    // One restoring step. R carries an extra bit so that a partial remainder of 2^32 or more still compares correctly.
    always_comb begin
        t      = {r[WIDTH-1:0], q[WIDTH-1]};
        s      = t - {1'b0, d};
        q_next = {q[WIDTH-2:0], ~s[WIDTH]};
        r_next = s[WIDTH] ? t : s;
    end

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            q           <= '0;
            d           <= '0;
            r           <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        busy <= 1'b1;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            out_valid   <= 1'b1;
                            state       <= DONE;
                        end else begin
                            q           <= dividend;
                            d           <= divisor;
                            r           <= '0;
                            cnt         <= CW'(WIDTH - 1);
                            div_by_zero <= 1'b0;
                            state       <= CALC;
                        end
                    end
                end
                CALC: begin
                    q   <= q_next;
                    r   <= r_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        quotient  <= q_next;
                        remainder <= r_next[WIDTH-1:0];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // The result stays registered until the consumer takes it. New operands wait for IDLE.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
